// File: rtl/fb_pkg.sv
// Shared constants and types for the rectangle-fill frame-buffer controller.
package fb_pkg;

  localparam int FB_W    = 120;
  localparam int FB_H    = 60;
  localparam int FB_SIZE = FB_W * FB_H;
  localparam int PIX_W   = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    GNT_A = 1'b0,
    GNT_B = 1'b1
  } grant_t;

  typedef struct packed {
    logic [6:0]       x;
    logic [5:0]       y;
    logic [7:0]       w;
    logic [6:0]       h;
    logic [PIX_W-1:0] color;
  } rect_cmd_t;

  function automatic logic [15:0] umin16(input logic [15:0] a, input logic [15:0] b);
    return (a < b) ? a : b;
  endfunction

  // Shift-and-add row offset; evaluated once per command, never per pixel.
  function automatic logic [15:0] row_offset(input logic [5:0] y, input logic [15:0] width);
    logic [15:0] acc;
    acc = '0;
    for (int i = 0; i < 6; i++) begin
      if (y[i]) acc = acc + (width << i);
    end
    return acc;
  endfunction

endpackage

// File: rtl/fb_rr_arb2.sv
// Two-way round-robin arbiter: grants only while enabled and remembers the last winner.
module fb_rr_arb2
  import fb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req_a,
  input  logic req_b,
  output logic grant_a,
  output logic grant_b
);

  grant_t last_reg;

  always_comb begin
    grant_a = en && req_a && (!req_b || (last_reg == GNT_B));
    grant_b = en && req_b && (!req_a || (last_reg == GNT_A));
  end

  // A grant implies a valid request, so this moves only on an accepted command.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_reg <= GNT_B;
    end else if (grant_a) begin
      last_reg <= GNT_A;
    end else if (grant_b) begin
      last_reg <= GNT_B;
    end
  end

endmodule

// File: rtl/fb_draw_ctrl.sv
// Rectangle-fill engine: arbitrates two requesters, clips to the frame and
// streams one pixel write per cycle in row-major order.
module fb_draw_ctrl #(
  parameter int FB_W = fb_pkg::FB_W,
  parameter int FB_H = fb_pkg::FB_H
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [6:0]  a_x,
  input  logic [5:0]  a_y,
  input  logic [7:0]  a_w,
  input  logic [6:0]  a_h,
  input  logic [2:0]  a_color,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [6:0]  b_x,
  input  logic [5:0]  b_y,
  input  logic [7:0]  b_w,
  input  logic [6:0]  b_h,
  input  logic [2:0]  b_color,
  output logic        wr,
  output logic [15:0] addr,
  output logic [2:0]  di,
  output logic        busy,
  output logic        done
);
  import fb_pkg::*;

  localparam logic [15:0] FB_W16 = 16'(FB_W);
  localparam logic [15:0] FB_H16 = 16'(FB_H);

  state_t           state_reg, state_next;
  rect_cmd_t        a_cmd, b_cmd, sel_cmd;
  logic             clip_empty;
  logic [7:0]       clip_w, ew_reg, ew_next, col_reg, col_next;
  logic [6:0]       clip_h, eh_reg, eh_next, row_reg, row_next;
  logic [15:0]      start_addr, row_base_reg, row_base_next, addr_reg, addr_next;
  logic [PIX_W-1:0] color_reg, color_next;

  assign a_cmd = '{x: a_x, y: a_y, w: a_w, h: a_h, color: a_color};
  assign b_cmd = '{x: b_x, y: b_y, w: b_w, h: b_h, color: b_color};

  fb_rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .en      (state_reg == IDLE),
    .req_a   (a_valid),
    .req_b   (b_valid),
    .grant_a (a_ready),
    .grant_b (b_ready)
  );

  // Clipping of whichever command is granted this cycle.
  always_comb begin
    sel_cmd    = b_ready ? b_cmd : a_cmd;
    clip_empty = (16'(sel_cmd.x) >= FB_W16) || (16'(sel_cmd.y) >= FB_H16) ||
                 (sel_cmd.w == '0) || (sel_cmd.h == '0);
    clip_w     = 8'(umin16(16'(sel_cmd.w), FB_W16 - 16'(sel_cmd.x)));
    clip_h     = 7'(umin16(16'(sel_cmd.h), FB_H16 - 16'(sel_cmd.y)));
    start_addr = row_offset(sel_cmd.y, FB_W16) + 16'(sel_cmd.x);
  end

  always_comb begin
    state_next    = state_reg;
    col_next      = col_reg;
    row_next      = row_reg;
    ew_next       = ew_reg;
    eh_next       = eh_reg;
    row_base_next = row_base_reg;
    addr_next     = addr_reg;
    color_next    = color_reg;
    case (state_reg)
      IDLE: begin
        if (a_ready || b_ready) begin
          if (clip_empty) begin
            state_next = DONE;
          end else begin
            state_next    = FILL;
            col_next      = '0;
            row_next      = '0;
            ew_next       = clip_w;
            eh_next       = clip_h;
            row_base_next = start_addr;
            addr_next     = start_addr;
            color_next    = sel_cmd.color;
          end
        end
      end
      FILL: begin
        if (col_reg == ew_reg - 8'd1) begin
          if (row_reg == eh_reg - 7'd1) begin
            state_next = DONE;
          end else begin
            row_next      = row_reg + 7'd1;
            col_next      = '0;
            row_base_next = row_base_reg + FB_W16;
            addr_next     = row_base_reg + FB_W16;
          end
        end else begin
          col_next  = col_reg + 8'd1;
          addr_next = addr_reg + 16'd1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A write must never coincide with an edge that samples reset.
  always_comb begin
    wr   = (state_reg == FILL) && !rst;
    busy = (state_reg != IDLE);
    done = (state_reg == DONE);
    addr = addr_reg;
    di   = color_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      col_reg      <= '0;
      row_reg      <= '0;
      ew_reg       <= '0;
      eh_reg       <= '0;
      row_base_reg <= '0;
      addr_reg     <= '0;
      color_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      col_reg      <= col_next;
      row_reg      <= row_next;
      ew_reg       <= ew_next;
      eh_reg       <= eh_next;
      row_base_reg <= row_base_next;
      addr_reg     <= addr_next;
      color_reg    <= color_next;
    end
  end

endmodule
